// File: rtl/cmult_share_arb.sv
// cmult_share_arb: round-robin arbiter feeding a two-stage pipeline around one
// shared complex multiplier. Requesters hand over operand pairs with
// valid/ready. Results come back on a single port tagged with the requester ID,
// and that port honours downstream backpressure.

// Full-precision complex multiply, purely combinational.
// The four partial products are formed at DINA_WIDTH+DINB_WIDTH bits, which
// holds every signed product, including full-scale negative times full-scale
// negative. The sum and difference are then widened by one bit, so they can
// never wrap.
module complex_mult #(
    parameter int DINA_WIDTH = 16,
    parameter int DINB_WIDTH = 16
) (
    input  logic signed [DINA_WIDTH-1:0]            a_i,
    input  logic signed [DINA_WIDTH-1:0]            a_q,
    input  logic signed [DINB_WIDTH-1:0]            b_i,
    input  logic signed [DINB_WIDTH-1:0]            b_q,
    output logic signed [DINA_WIDTH+DINB_WIDTH:0]   p_i,
    output logic signed [DINA_WIDTH+DINB_WIDTH:0]   p_q
);
    localparam int PW = DINA_WIDTH + DINB_WIDTH;

    logic signed [PW-1:0] ai_x, aq_x, bi_x, bq_x;
    logic signed [PW-1:0] p_ii, p_qq, p_iq, p_qi;

    assign ai_x = $signed({{DINB_WIDTH{a_i[DINA_WIDTH-1]}}, a_i});
    assign aq_x = $signed({{DINB_WIDTH{a_q[DINA_WIDTH-1]}}, a_q});
    assign bi_x = $signed({{DINA_WIDTH{b_i[DINB_WIDTH-1]}}, b_i});
    assign bq_x = $signed({{DINA_WIDTH{b_q[DINB_WIDTH-1]}}, b_q});

    assign p_ii = ai_x * bi_x;
    assign p_qq = aq_x * bq_x;
    assign p_iq = ai_x * bq_x;
    assign p_qi = aq_x * bi_x;

    assign p_i = $signed({p_ii[PW-1], p_ii}) - $signed({p_qq[PW-1], p_qq});
    assign p_q = $signed({p_iq[PW-1], p_iq}) + $signed({p_qi[PW-1], p_qi});
endmodule

module cmult_share_arb #(
    parameter  int NUM_REQ    = 4,
    parameter  int ID_WIDTH   = 2,
    parameter  int DINA_WIDTH = 16,
    parameter  int DINB_WIDTH = 16,
    localparam int MULT_WIDTH = DINA_WIDTH + DINB_WIDTH + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DINA_WIDTH-1:0]    req_a_i,
    input  logic [NUM_REQ*DINA_WIDTH-1:0]    req_a_q,
    input  logic [NUM_REQ*DINB_WIDTH-1:0]    req_b_i,
    input  logic [NUM_REQ*DINB_WIDTH-1:0]    req_b_q,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [ID_WIDTH-1:0]              res_id,
    output logic signed [MULT_WIDTH-1:0]     res_i,
    output logic signed [MULT_WIDTH-1:0]     res_q
);
    // Per-requester operand views, unpacked from the flat buses.
    logic [DINA_WIDTH-1:0] a_i_arr [NUM_REQ];
    logic [DINA_WIDTH-1:0] a_q_arr [NUM_REQ];
    logic [DINB_WIDTH-1:0] b_i_arr [NUM_REQ];
    logic [DINB_WIDTH-1:0] b_q_arr [NUM_REQ];

    logic                  advance;
    logic                  grant_found;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH:0]     cand;
    logic                  xfer;

    logic [ID_WIDTH-1:0]   rr_ptr_reg;

    logic                  s1_valid_reg;
    logic [ID_WIDTH-1:0]   s1_id_reg;
    logic signed [DINA_WIDTH-1:0] s1_a_i_reg, s1_a_q_reg;
    logic signed [DINB_WIDTH-1:0] s1_b_i_reg, s1_b_q_reg;

    logic signed [MULT_WIDTH-1:0] mult_i, mult_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_i_arr[gi] = req_a_i[gi*DINA_WIDTH +: DINA_WIDTH];
            assign a_q_arr[gi] = req_a_q[gi*DINA_WIDTH +: DINA_WIDTH];
            assign b_i_arr[gi] = req_b_i[gi*DINB_WIDTH +: DINB_WIDTH];
            assign b_q_arr[gi] = req_b_q[gi*DINB_WIDTH +: DINB_WIDTH];
            // Gated by rst_n, so no requester sees an accept while reset is held.
            assign req_ready[gi] = rst_n && advance && grant_found &&
                                   (grant_id == ID_WIDTH'(gi));
        end
    endgenerate

    // The whole pipeline moves as one unit, and only when the output slot is free.
    assign advance = !res_valid || res_ready;
    assign xfer    = rst_n && advance && grant_found;

    // Round-robin search: the first valid requester at or above rr_ptr wins,
    // wrapping around past NUM_REQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(j);
            if (cand >= (ID_WIDTH+1)'(NUM_REQ))
                cand = cand - (ID_WIDTH+1)'(NUM_REQ);
            if (!grant_found && req_valid[cand[ID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_WIDTH-1:0];
            end
        end
    end

    // Priority pointer: moves just past the winner, and only on an actual transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (xfer) begin
            if (grant_id == ID_WIDTH'(NUM_REQ - 1))
                rr_ptr_reg <= '0;
            else
                rr_ptr_reg <= grant_id + 1'b1;
        end
    end

    // Stage 1: capture the winner's operands and ID. On a bubble, only the
    // valid flag clears; the operand registers keep their old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_id_reg    <= '0;
            s1_a_i_reg   <= '0;
            s1_a_q_reg   <= '0;
            s1_b_i_reg   <= '0;
            s1_b_q_reg   <= '0;
        end else if (advance) begin
            s1_valid_reg <= xfer;
            if (xfer) begin
                s1_id_reg  <= grant_id;
                s1_a_i_reg <= a_i_arr[grant_id];
                s1_a_q_reg <= a_q_arr[grant_id];
                s1_b_i_reg <= b_i_arr[grant_id];
                s1_b_q_reg <= b_q_arr[grant_id];
            end
        end
    end

    complex_mult #(
        .DINA_WIDTH (DINA_WIDTH),
        .DINB_WIDTH (DINB_WIDTH)
    ) u_cmult (
        .a_i (s1_a_i_reg),
        .a_q (s1_a_q_reg),
        .b_i (s1_b_i_reg),
        .b_q (s1_b_q_reg),
        .p_i (mult_i),
        .p_q (mult_q)
    );

    // Stage 2: register the product and ID. The payload loads only for a
    // valid stage-1 entry, so it stays put during stalls and bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_i     <= '0;
            res_q     <= '0;
        end else if (advance) begin
            res_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                res_id <= s1_id_reg;
                res_i  <= mult_i;
                res_q  <= mult_q;
            end
        end
    end
endmodule

// File: tb/tb_cmult_share_arb.sv
// Randomised plus directed bench for cmult_share_arb. The stimulus side
// predicts grants from a round-robin model and pushes the expected products
// into a queue. A separate monitor pops that queue whenever the DUT delivers
// a result.
module tb_cmult_share_arb;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int DW = 16;
    localparam int MW = 2*DW + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a_i, req_a_q, req_b_i, req_b_q;
    logic              res_valid;
    logic              res_ready;
    logic [IW-1:0]     res_id;
    logic [MW-1:0]     res_i, res_q;

    cmult_share_arb #(
        .NUM_REQ(N), .ID_WIDTH(IW), .DINA_WIDTH(DW), .DINB_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a_i(req_a_i), .req_a_q(req_a_q),
        .req_b_i(req_b_i), .req_b_q(req_b_q),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_i(res_i), .res_q(res_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     id;
        longint ei;
        longint eq;
    } exp_t;

    exp_t   sb[$];
    int     glog[$];
    int     checks   = 0;
    int     failures = 0;

    // Requester-side state: pending flag and operands per requester.
    bit                  pend [N];
    logic signed [DW-1:0] oai [N], oaq [N], obi [N], obq [N];
    int                  keep_all = 0;
    int                  rate     = 0;

    // Reference model: occupancy of the two pipeline slots and the priority pointer.
    bit m_s1v = 1'b0;
    bit m_s2v = 1'b0;
    int m_ptr = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k]            = pend[k];
            req_a_i[k*DW +: DW]     = oai[k];
            req_a_q[k*DW +: DW]     = oaq[k];
            req_b_i[k*DW +: DW]     = obi[k];
            req_b_q[k*DW +: DW]     = obq[k];
        end
    endtask

    task automatic set_req(input int k, input int ai, input int aq, input int bi, input int bq);
        pend[k] = 1'b1;
        oai[k]  = 16'(ai);
        oaq[k]  = 16'(aq);
        obi[k]  = 16'(bi);
        obq[k]  = 16'(bq);
    endtask

    task automatic rand_req(input int k);
        set_req(k, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
    endtask

    // One clock cycle. Expectations are checked at the falling edge; inputs
    // change 1 time unit after the rising edge.
    task automatic step();
        int         w;
        bit         found;
        bit         adv;
        logic [N-1:0] er;
        exp_t       e;
        @(negedge clk);
        found = 1'b0;
        w     = 0;
        for (int j = 0; j < N; j++) begin
            int c;
            c = (m_ptr + j) % N;
            if (!found && pend[c]) begin
                found = 1'b1;
                w     = c;
            end
        end
        adv = !m_s2v || res_ready;
        er  = '0;
        if (adv && found) er[w] = 1'b1;
        check("req_ready", longint'(req_ready), longint'(er));
        check("res_valid", longint'(res_valid), longint'(m_s2v));
        for (int k = 0; k < N; k++)
            if (req_ready[k]) glog.push_back(k);
        if (adv && found) begin
            e.id = w;
            e.ei = longint'(oai[w]) * longint'(obi[w]) - longint'(oaq[w]) * longint'(obq[w]);
            e.eq = longint'(oai[w]) * longint'(obq[w]) + longint'(oaq[w]) * longint'(obi[w]);
            sb.push_back(e);
            m_ptr = (w + 1) % N;
        end
        if (adv) begin
            m_s2v = m_s1v;
            m_s1v = adv && found;
        end
        @(posedge clk);
        #1;
        if (adv && found) begin
            if (keep_all != 0) rand_req(w);
            else pend[w] = 1'b0;
        end
        if (rate > 0)
            for (int k = 0; k < N; k++)
                if (!pend[k] && ($urandom_range(0, 99) < rate)) rand_req(k);
        drive();
    endtask

    // Called 1 time unit after a rising edge. Holds reset for one cycle.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_res_valid", longint'(res_valid), 0);
        check("rst_res_id", longint'(res_id), 0);
        check("rst_res_i", longint'(res_i), 0);
        check("rst_res_q", longint'(res_q), 0);
        check("rst_req_ready", longint'(req_ready), 0);
        m_s1v = 1'b0;
        m_s2v = 1'b0;
        m_ptr = 0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_reqs();
        drive();
    endtask

    // Monitor: pops a result on each accepted output and checks that a
    // stalled output holds steady.
    bit          stalled = 1'b0;
    logic [IW-1:0] hold_id;
    logic [MW-1:0] hold_i, hold_q;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", longint'(res_valid), 1);
                check("stall_id", longint'(res_id), longint'(hold_id));
                check("stall_i", longint'($signed(res_i)), longint'($signed(hold_i)));
                check("stall_q", longint'($signed(res_q)), longint'($signed(hold_q)));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual_id=%0d required=none", res_id);
                end else begin
                    e = sb.pop_front();
                    $display("result id=%0d i=%0d q=%0d (exp id=%0d i=%0d q=%0d)",
                             res_id, $signed(res_i), $signed(res_q), e.id, e.ei, e.eq);
                    check("res_id", longint'(res_id), longint'(e.id));
                    check("res_i", longint'($signed(res_i)), e.ei);
                    check("res_q", longint'($signed(res_q)), e.eq);
                end
            end
            stalled = res_valid && !res_ready;
            hold_id = res_id;
            hold_i  = res_i;
            hold_q  = res_q;
        end
    end

    initial begin
        int exp_wrap [3];
        exp_wrap[0] = 3;
        exp_wrap[1] = 0;
        exp_wrap[2] = 1;

        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            oai[k] = '0; oaq[k] = '0; obi[k] = '0; obq[k] = '0;
        end
        req_valid = '0;
        req_a_i = '0; req_a_q = '0; req_b_i = '0; req_b_q = '0;
        res_ready = 1'b1;
        rst_n = 1'b0;
        set_req(2, 1, 1, 1, 1);
        drive();

        // Reset state, with a requester already valid.
        repeat (2) @(posedge clk);
        #1;
        check("reset_res_valid", longint'(res_valid), 0);
        check("reset_res_id", longint'(res_id), 0);
        check("reset_res_i", longint'(res_i), 0);
        check("reset_res_q", longint'(res_q), 0);
        check("reset_req_ready", longint'(req_ready), 0);
        rst_n = 1'b1;
        clear_reqs();
        drive();

        // All requesters continuously valid: grants must go 0,1,2,3,0,1,...
        keep_all = 1;
        for (int k = 0; k < N; k++) rand_req(k);
        drive();
        glog.delete();
        repeat (8) step();
        keep_all = 0;
        clear_reqs();
        drive();
        check("fair_grant_count", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            check("fair_grant_order", glog[i], i % N);
        repeat (3) step();

        // Single request from requester 2: (3+4j)*(5-2j) = 23+14j.
        set_req(2, 3, 4, 5, -2);
        drive();
        repeat (3) step();

        // Pointer wrap: the pointer now sits at 3, so 3 and 0 are granted in
        // that order. A following 0+1 pair must then grant 1.
        glog.delete();
        set_req(3, int'($urandom), 7, -9, 11);
        set_req(0, -5, 6, 7, -8);
        drive();
        step();
        step();
        set_req(0, 1, 2, 3, 4);
        set_req(1, -1, -2, -3, -4);
        drive();
        step();
        clear_reqs();
        drive();
        for (int i = 0; i < 3 && i < glog.size(); i++)
            check("wrap_grant", glog[i], exp_wrap[i]);
        repeat (3) step();

        // Backpressure: two results in flight, then 3 stalled cycles while
        // another requester waits.
        rand_req(0);
        rand_req(1);
        drive();
        step();
        step();
        res_ready = 1'b0;
        rand_req(2);
        drive();
        repeat (3) step();
        res_ready = 1'b1;
        repeat (4) step();

        // Full-scale operands.
        set_req(1, -32768, -32768, -32768, -32768);
        set_req(3, -32768, 32767, 32767, -32768);
        drive();
        repeat (4) step();

        // Reset mid-stream with both stages occupied.
        keep_all = 1;
        for (int k = 0; k < N; k++) rand_req(k);
        drive();
        repeat (3) step();
        keep_all = 0;
        reset_pulse();
        set_req(2, -123, 456, 789, -1011);
        drive();
        repeat (4) step();

        // Random traffic with random backpressure.
        rate = 40;
        for (int c = 0; c < 300; c++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rate = 0;
        clear_reqs();
        res_ready = 1'b1;
        drive();
        repeat (5) step();

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
